// File: rtl/fp16_pkg.sv
// Shared FP16 field definitions, converter state and special-case kinds.
// Field-extract helpers for sign, biased exponent and stored mantissa.
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_MAN_W   = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        K_NORM,
        K_ZERO,
        K_SAT,
        K_NAN
    } kind_t;

    function automatic logic fp16_sign(input logic [15:0] a);
        return a[15];
    endfunction

    function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [15:0] a);
        return a[14:10];
    endfunction

    function automatic logic [FP16_MAN_W-1:0] fp16_man(input logic [15:0] a);
        return a[9:0];
    endfunction

endpackage

// File: rtl/fp16_to_fixed_if.sv
// Handshake bundle of the FP16-to-fixed converter: operand side (in_valid,
// in_ready, A) and result side (out_valid, out_ready, Q, ovf, invalid).
interface fp16_to_fixed_if #(
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      A;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] Q;
    logic             ovf;
    logic             invalid;

    modport master (
        output in_valid, A, out_ready,
        input  in_ready, out_valid, Q, ovf, invalid
    );

    modport slave (
        input  in_valid, A, out_ready,
        output in_ready, out_valid, Q, ovf, invalid
    );
endinterface

// File: rtl/fp16_unpack.sv
// Combinational FP16 split: a -> s, unbiased e, m={1,man}, and
// is_zero (exp==0, subnormals included), is_inf, is_nan classification.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic              [15:0] a,
    output logic                     s,
    output logic signed       [7:0]  e,
    output logic              [10:0] m,
    output logic                     is_zero,
    output logic                     is_inf,
    output logic                     is_nan
);
    logic [FP16_EXP_W-1:0] ex;
    logic [FP16_MAN_W-1:0] mn;

    always_comb begin
        ex      = fp16_exp(a);
        mn      = fp16_man(a);
        s       = fp16_sign(a);
        e       = {3'b000, ex} - 8'(FP16_BIAS);
        m       = {1'b1, mn};
        is_zero = (ex == '0);
        is_inf  = (ex == 5'(FP16_EXP_MAX)) && (mn == '0);
        is_nan  = (ex == 5'(FP16_EXP_MAX)) && (mn != '0);
    end
endmodule

// File: rtl/fp16_to_fixed.sv
// FP16 to signed fixed point (value*2^FRAC_W) with a one-bit-per-cycle aligner.
// Ports: clk, rst (async high), bus (slave). Macro ROUND_NEAREST_EN selects RNE.
module fp16_to_fixed
    import fp16_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    fp16_to_fixed_if.slave bus
);
    localparam logic signed [7:0] SAT_E  = 8'(OUT_W - 1 - FRAC_W);
    localparam logic signed [7:0] SH_OFF = 8'(FRAC_W - FP16_MAN_W);
    localparam logic [OUT_W-1:0]  Q_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  Q_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    logic              u_s;
    logic signed [7:0] u_e;
    logic [10:0]       u_m;
    logic              u_zero;
    logic              u_inf;
    logic              u_nan;

    fp16_unpack u_unpack (
        .a       (bus.A),
        .s       (u_s),
        .e       (u_e),
        .m       (u_m),
        .is_zero (u_zero),
        .is_inf  (u_inf),
        .is_nan  (u_nan)
    );

    state_t           state;
    kind_t            kind;
    kind_t            kind_nxt;
    logic             sgn;
    logic             left;
    logic             sat_ovf;
    logic [3:0]       cnt;
    logic [OUT_W-1:0] mag;
`ifdef ROUND_NEAREST_EN
    logic             guard;
    logic             sticky;
`endif

    logic signed [7:0] sh;
    logic [7:0]        sh_abs;
    logic [3:0]        k;
    logic              big;
    logic              inc;
    logic [OUT_W:0]    mag_r;

    always_comb begin
        sh     = u_e + SH_OFF;
        sh_abs = sh[7] ? $unsigned(-sh) : $unsigned(sh);
        // beyond 13 right shifts every mantissa bit is already in sticky
        k      = (sh_abs > 8'd13) ? 4'd13 : sh_abs[3:0];
        big    = (u_e >= SAT_E);
        if (u_nan)
            kind_nxt = K_NAN;
        else if (u_inf || big)
            kind_nxt = K_SAT;
        else if (u_zero)
            kind_nxt = K_ZERO;
        else
            kind_nxt = K_NORM;
    end

    always_comb begin
        inc = 1'b0;
`ifdef ROUND_NEAREST_EN
        inc = guard & (sticky | mag[0]);
`endif
        mag_r = {1'b0, mag} + (OUT_W+1)'(inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            kind          <= K_NORM;
            sgn           <= 1'b0;
            left          <= 1'b0;
            sat_ovf       <= 1'b0;
            cnt           <= '0;
            mag           <= '0;
`ifdef ROUND_NEAREST_EN
            guard         <= 1'b0;
            sticky        <= 1'b0;
`endif
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.Q         <= '0;
            bus.ovf       <= 1'b0;
            bus.invalid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sgn          <= u_s;
                        left         <= !sh[7];
                        cnt          <= k;
                        mag          <= OUT_W'(u_m);
                        kind         <= kind_nxt;
                        // exactly -2^(OUT_W-1-FRAC_W) is representable
                        sat_ovf      <= u_inf || !(u_s && u_e == SAT_E
                                                   && u_m[9:0] == '0);
`ifdef ROUND_NEAREST_EN
                        guard        <= 1'b0;
                        sticky       <= 1'b0;
`endif
                        bus.ovf      <= 1'b0;
                        bus.invalid  <= 1'b0;
                        bus.in_ready <= 1'b0;
                        state        <= (kind_nxt == K_NORM && k != 4'd0)
                                        ? ALIGN : ROUND;
                    end
                end
                ALIGN: begin
                    if (left) begin
                        mag <= mag << 1;
                    end else begin
                        mag    <= mag >> 1;
`ifdef ROUND_NEAREST_EN
                        guard  <= mag[0];
                        sticky <= sticky | guard;
`endif
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ROUND;
                end
                ROUND: begin
                    unique case (kind)
                        K_NAN: begin
                            bus.Q       <= '0;
                            bus.invalid <= 1'b1;
                        end
                        K_ZERO: begin
                            bus.Q <= '0;
                        end
                        K_SAT: begin
                            bus.Q   <= sgn ? Q_MIN : Q_MAX;
                            bus.ovf <= sat_ovf;
                        end
                        default: begin
                            if (!sgn && mag_r[OUT_W:OUT_W-1] != 2'b00) begin
                                bus.Q   <= Q_MAX;
                                bus.ovf <= 1'b1;
                            end else begin
                                bus.Q <= sgn ? OUT_W'(-mag_r)
                                             : OUT_W'(mag_r);
                            end
                        end
                    endcase
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_to_fixed.sv
// Randomised self-checking bench for fp16_to_fixed (OUT_W=16, FRAC_W=4)
// against an exact integer-arithmetic model of the conversion.
module tb_fp16_to_fixed;
    localparam int OUT_W  = 16;
    localparam int FRAC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp16_to_fixed_if #(.OUT_W(OUT_W)) bus ();

    fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // value*2^FRAC_W computed exactly, then rounded and clamped
    function automatic void model(input logic [15:0] a,
                                  output logic [15:0] q, output logic ov,
                                  output logic inv, output int k);
        int     ex, mn, e, sh, d, sa;
        longint mag, v, div;
`ifdef ROUND_NEAREST_EN
        longint rem;
`endif
        ex = int'(a[14:10]);
        mn = int'(a[9:0]);
        q = 16'h0; ov = 1'b0; inv = 1'b0; k = 0;
        if (ex == 31) begin
            if (mn != 0) inv = 1'b1;
            else begin
                ov = 1'b1;
                q  = a[15] ? 16'h8000 : 16'h7fff;
            end
        end else if (ex != 0) begin
            e   = ex - 15;
            sh  = e + FRAC_W - 10;
            mag = longint'(1024 + mn);
            if (sh >= 0) begin
                mag = mag * (longint'(1) << sh);
            end else begin
                d   = -sh;
                div = longint'(1) << d;
`ifdef ROUND_NEAREST_EN
                rem = mag % div;
`endif
                mag = mag / div;
`ifdef ROUND_NEAREST_EN
                if (2 * rem > div || (2 * rem == div && mag % 2 == 1))
                    mag++;
`endif
            end
            v = a[15] ? -mag : mag;
            if (v > longint'(32767)) begin
                q = 16'h7fff; ov = 1'b1;
            end else if (v < -longint'(32768)) begin
                q = 16'h8000; ov = 1'b1;
            end else begin
                q = 16'(v);
            end
            if (e < OUT_W - 1 - FRAC_W) begin
                sa = (sh < 0) ? -sh : sh;
                k  = (sa > 13) ? 13 : sa;
            end
        end
    endfunction

    // called at a negedge; returns at the negedge after the accept edge
    task automatic drive(input logic [15:0] a);
        int n;
        bus.in_valid = 1'b1;
        bus.A        = a;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = 16'($urandom);
    endtask

    task automatic run_op(input logic [15:0] a, input int hold);
        logic [15:0] eq;
        logic        eo, ei;
        int          ek, cnt;
        model(a, eq, eo, ei, ek);
        drive(a);
        bus.out_ready = (hold == 0);
        check("busy_in_ready", 32'(bus.in_ready), 32'd0);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check($sformatf("lat_%h", a), 32'(cnt + 1), 32'(ek + 2));
        check($sformatf("q_%h", a), 32'(bus.Q), 32'(eq));
        check($sformatf("ovf_%h", a), 32'(bus.ovf), 32'(eo));
        check($sformatf("inv_%h", a), 32'(bus.invalid), 32'(ei));
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'($urandom);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_q", 32'(bus.Q), 32'(eq));
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_q"}, 32'(bus.Q), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
        check({tag, "_invalid"}, 32'(bus.invalid), 32'd0);
    endtask

    logic [15:0] dir_ops [16] = '{
        16'h3c00, 16'hc100, 16'h6000, 16'h2a00,
        16'h2c00, 16'h7000, 16'hfc00, 16'h7e00,
        16'h8000, 16'h0000, 16'h0001, 16'h7bff,
        16'he800, 16'he801, 16'h2800, 16'h2e00
    };

    initial begin
        logic [15:0] a;
        bus.in_valid  = 1'b0;
        bus.A         = 16'h0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (dir_ops[i]) run_op(dir_ops[i], 0);

        run_op(16'h3c00, 5);
        run_op(16'hc100, 0);

        run_op(16'hfc00, 0);
        drive(16'h2a00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h3c00, 0);

        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                a[14:10] = 5'($urandom_range(5, 18));
            run_op(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
